// File: rtl/nios_cpu_gpo_pulse_pkg.sv
// Shared definitions for the GPO pulse port: register map and timer state encoding.
package nios_cpu_gpo_pulse_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_PULSE_MASK = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS     = 3'd5;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/nios_cpu_gpo_pulse_if.sv
// Avalon-MM slave signal bundle for the GPO pulse port.
interface nios_cpu_gpo_pulse_if;
  import nios_cpu_gpo_pulse_pkg::*;

  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_cpu_gpo_pulse_timer.sv
// Shared pulse-length down-counter: load/restart, busy flag, one-cycle expire strobe.
//   state    | meaning
//   TMR_IDLE | no pulse pending, counter held at 0
//   TMR_RUN  | counting down; expire fires while the count is 1
module nios_cpu_gpo_pulse_timer
  import nios_cpu_gpo_pulse_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             busy_o,
  output logic             expire_o
);

  tmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TMR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A load wins over expiry so a rise on the expiry cycle restarts the pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    expire_o = (state_q == TMR_RUN) && (cnt_q == CNT_W'(1));
    if (load_i) begin
      state_d = TMR_RUN;
      cnt_d   = (len_i == '0) ? CNT_W'(1) : len_i;
    end else if (state_q == TMR_RUN) begin
      if (expire_o) begin
        state_d = TMR_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  assign busy_o = (state_q == TMR_RUN);

endmodule

// File: rtl/nios_cpu_gpo_pulse.sv
// Avalon-MM general-purpose output port with set/clear writes and per-bit auto-clear pulses.
module nios_cpu_gpo_pulse
  import nios_cpu_gpo_pulse_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int unsigned      CNT_W         = 16,
  parameter logic [CNT_W-1:0] PULSE_DEFAULT = CNT_W'(1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios_cpu_gpo_pulse_if.slave  bus,
  output logic [WIDTH-1:0]     out_port,
  output logic                 pulse_busy
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] base, wd;
  logic             wr_en, rise, busy, expire;
  logic             unused_wd;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  // Expiry clear is applied first; the write then lands on top of it.
  assign base = expire ? (data_q & ~mask_q) : data_q;

  always_comb begin
    data_d = base;
    mask_d = mask_q;
    len_d  = len_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:       data_d = wd;
        ADDR_PULSE_MASK: mask_d = wd;
        ADDR_OUTSET:     data_d = base | wd;
        ADDR_OUTCLEAR:   data_d = base & ~wd;
        ADDR_PULSE_LEN:  len_d  = bus.writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // Only DATA and OUTSET can raise a bit, so this covers exactly those writes.
  assign rise = |(~base & data_d & mask_q);

  always_comb begin
    rdata_d = '0;
    case (bus.address)
      ADDR_DATA:       rdata_d[WIDTH-1:0] = data_q;
      ADDR_PULSE_MASK: rdata_d[WIDTH-1:0] = mask_q;
      ADDR_PULSE_LEN:  rdata_d[CNT_W-1:0] = len_q;
      ADDR_STATUS:     rdata_d[0]         = busy;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE;
      mask_q  <= '0;
      len_q   <= PULSE_DEFAULT;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      rdata_q <= rdata_d;
    end
  end

  nios_cpu_gpo_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (rise),
    .len_i    (len_q),
    .busy_o   (busy),
    .expire_o (expire)
  );

  assign bus.readdata = rdata_q;
  assign out_port     = data_q;
  assign pulse_busy   = busy;

endmodule

// File: tb/tb_nios_cpu_gpo_pulse.sv
// Directed bench for the GPO pulse port: register table plus pulse timing sequences.
module tb_nios_cpu_gpo_pulse;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] out_port;
  logic       pulse_busy;
  int         checks = 0;
  int         errors = 0;

  nios_cpu_gpo_pulse_if bus();

  nios_cpu_gpo_pulse #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .CNT_W       (16),
    .PULSE_DEFAULT (16'd1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic        exp_busy;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Counts cycles with bit0 high and with busy high until both drop (bounded).
  task automatic measure(output int hi, output int bz);
    hi = 0;
    bz = 0;
    for (int k = 0; k < 20; k++) begin
      if (!out_port[0] && !pulse_busy) break;
      if (out_port[0]) hi++;
      if (pulse_busy) bz++;
      @(negedge clk);
    end
  endtask

  initial begin
    int hi, bz;

    vecs[0]  = '{1'b0, 3'd4, 32'h0,         8'hA5, 1'b0, 1'b1, 32'h1};
    vecs[1]  = '{1'b1, 3'd0, 32'h0F,        8'h0F, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 3'd2, 32'hF0,        8'hFF, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 3'd3, 32'h3C,        8'hC3, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 3'd0, 32'h0,         8'hC3, 1'b0, 1'b1, 32'hC3};
    vecs[5]  = '{1'b1, 3'd6, 32'hFFFFFFFF,  8'hC3, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 3'd7, 32'hFFFFFFFF,  8'hC3, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'd6, 32'h0,         8'hC3, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 3'd7, 32'h0,         8'hC3, 1'b0, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 3'd2, 32'h0,         8'hC3, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 3'd3, 32'h0,         8'hC3, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 3'd1, 32'h0,         8'hC3, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 3'd4, 32'h0,         8'hC3, 1'b0, 1'b1, 32'h1};
    vecs[13] = '{1'b0, 3'd5, 32'h0,         8'hC3, 1'b0, 1'b1, 32'h0};
    vecs[14] = '{1'b1, 3'd1, 32'hFFFFFF01,  8'hC3, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 3'd1, 32'h0,         8'hC3, 1'b0, 1'b1, 32'h1};
    vecs[16] = '{1'b1, 3'd4, 32'h00010005,  8'hC3, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 3'd4, 32'h0,         8'hC3, 1'b0, 1'b1, 32'h5};
    vecs[18] = '{1'b1, 3'd0, 32'h0,         8'h00, 1'b0, 1'b0, 32'h0};
    vecs[19] = '{1'b0, 3'd0, 32'h0,         8'h00, 1'b0, 1'b1, 32'h0};

    reset_n        = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'h0;
    idle(3);
    chk("rst_out",  32'(out_port),   32'hA5);
    chk("rst_rd",   bus.readdata,    32'h0);
    chk("rst_busy", 32'(pulse_busy), 32'h0);
    reset_n = 1'b1;
    idle(1);

    for (int i = 0; i < 20; i++) begin
      bus.address   = vecs[i].addr;
      bus.writedata = vecs[i].wd;
      if (vecs[i].is_wr) begin
        do_wr(vecs[i].addr, vecs[i].wd);
      end else begin
        idle(1);
      end
      chk($sformatf("vec%0d_out", i),  32'(out_port),   32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_busy", i), 32'(pulse_busy), 32'(vecs[i].exp_busy));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), bus.readdata, vecs[i].exp_rd);
    end

    // Pulse width 5, mask 01
    do_wr(3'd2, 32'h1);
    chk("pw_start_out",  32'(out_port),   32'h01);
    chk("pw_start_busy", 32'(pulse_busy), 32'h1);
    measure(hi, bz);
    chk("pw_hi", hi, 5);
    chk("pw_bz", bz, 5);
    chk("pw_end_out", 32'(out_port), 32'h00);

    // Length 0 behaves as 1
    do_wr(3'd4, 32'h0);
    do_wr(3'd2, 32'h1);
    measure(hi, bz);
    chk("len0_hi", hi, 1);
    chk("len0_bz", bz, 1);

    // Restart: clear then set again at count 2
    do_wr(3'd4, 32'h4);
    do_wr(3'd2, 32'h1);
    idle(1);
    do_wr(3'd3, 32'h1);
    chk("rs_clr_out",  32'(out_port),   32'h00);
    chk("rs_clr_busy", 32'(pulse_busy), 32'h1);
    do_wr(3'd2, 32'h1);
    measure(hi, bz);
    chk("rs_hi", hi, 4);
    chk("rs_bz", bz, 4);

    // Expiry collision with a masked set: reload
    do_wr(3'd4, 32'h3);
    do_wr(3'd2, 32'h1);
    idle(2);
    do_wr(3'd2, 32'h1);
    chk("col1_out",  32'(out_port),   32'h01);
    chk("col1_busy", 32'(pulse_busy), 32'h1);
    measure(hi, bz);
    chk("col1_hi", hi, 3);

    // Expiry collision with an unmasked set: bit0 clears, bit1 stays
    do_wr(3'd2, 32'h1);
    idle(2);
    do_wr(3'd2, 32'h2);
    chk("col2_out",  32'(out_port),   32'h02);
    chk("col2_busy", 32'(pulse_busy), 32'h0);
    idle(5);
    chk("col2_hold", 32'(out_port), 32'h02);
    do_wr(3'd3, 32'hFF);
    chk("col2_clr", 32'(out_port), 32'h00);

    // Reset while busy with counter at 3
    do_wr(3'd4, 32'h5);
    do_wr(3'd2, 32'h1);
    idle(2);
    reset_n = 1'b0;
    #1;
    chk("mrst_out",  32'(out_port),   32'hA5);
    chk("mrst_busy", 32'(pulse_busy), 32'h0);
    chk("mrst_rd",   bus.readdata,    32'h0);
    idle(1);
    reset_n     = 1'b1;
    bus.address = 3'd4;
    idle(1);
    chk("mrst_len", bus.readdata, 32'h1);
    bus.address = 3'd1;
    idle(1);
    chk("mrst_mask", bus.readdata, 32'h0);
    chk("mrst_out2", 32'(out_port), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_cpu_gpo_pulse.md
Name: nios_cpu_gpo_pulse

Overview:
Avalon-MM slave general-purpose output port for the Nios CPU subsystem; the write-side counterpart of the existing read-only GPI ports. Holds a registered output word driven to fabric pins and control logic. Supports atomic set/clear writes and an optional per-bit auto-clear pulse mode timed by a programmable cycle counter.

Parameters:
WIDTH, 8, number of output bits (1..32)
RESET_VALUE, 0, out_port value after reset (WIDTH bits)
CNT_W, 16, pulse-length counter width (1..32)
PULSE_DEFAULT, 1, pulse_len reset value

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
chipselect  in  1  Avalon slave select
address  in  3  register word address
write_n  in  1  active-low write strobe, qualified by chipselect
writedata  in  32  write data
readdata  out  32  registered read data
out_port  out  WIDTH  output word, direct from data_reg
pulse_busy  out  1  pulse counter running

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on reset_n; all registers clear on assertion.
- Reset values: data_reg=RESET_VALUE, pulse_mask=0, pulse_len=PULSE_DEFAULT, counter=0, busy=0, readdata=0.
- Write is valid when chipselect=1 and write_n=0, in a single cycle with no wait states. Only writedata[WIDTH-1:0] is used for bit registers.
- Register map:
  - 0 DATA (RW): data_reg <= wd.
  - 1 PULSE_MASK (RW).
  - 2 OUTSET (WO, reads 0): data_reg <= data_reg | wd.
  - 3 OUTCLEAR (WO, reads 0): data_reg <= data_reg & ~wd.
  - 4 PULSE_LEN (RW, CNT_W bits): a value of 0 behaves as 1.
  - 5 STATUS (RO): bit0=busy, bit[31:1]=0.
  - 6 and 7: writes ignored, reads 0.
- Read: readdata is registered every clk from the current address, regardless of chipselect. Latency is 1 cycle. Unused upper bits read 0.
- Write latency: a write accepted at edge N is visible on out_port after edge N.
- Pulse trigger ("rise"): any write to DATA or OUTSET whose result takes a pulse_mask bit from 0 to 1.
- On rise: counter <= max(pulse_len,1) and busy <= 1. A rise while busy restarts the counter; there is one shared counter.
- While busy and no rise: the counter decrements each cycle. At the edge where counter==1:
  - data_reg &= ~pulse_mask, using pulse_mask as sampled that cycle;
  - busy <= 0 and counter <= 0.
- Resulting timing: a masked bit set by a single write is high on out_port for exactly pulse_len cycles.
- Expiry and write in the same cycle: the expiry clear is applied first, then the write on top of it. If the write produces a rise, the counter reloads and busy stays 1.
- Changing pulse_mask or pulse_len while busy does not alter the running count. The new mask takes effect at expiry; the new length applies at the next rise.
- OUTCLEAR during busy does not stop the counter; expiry still occurs and is harmless.
- Unmasked bits are never auto-cleared.
- Reset mid-pulse: out_port returns to RESET_VALUE immediately and busy=0.
- pulse_busy mirrors STATUS bit0.

Decomposition:
- Shared package: register address constants (ADDR_DATA=0, ADDR_PULSE_MASK=1, ADDR_OUTSET=2, ADDR_OUTCLEAR=3, ADDR_PULSE_LEN=4, ADDR_STATUS=5).
- One natural sub-module: nios_cpu_gpo_pulse_timer. It holds the CNT_W down-counter with load/restart, exposes busy, and emits a one-cycle expire strobe.
- The register file and read mux stay in the top level.

Test Plan:
- Reset check: assert reset_n=0 with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata=0, busy=0. Read addr 4 -> PULSE_DEFAULT after 1 cycle.
- Set/clear: write DATA=8'h0F, OUTSET=8'hF0, OUTCLEAR=8'h3C -> out_port sequence 0F, FF, C3; read addr 0 returns 32'h000000C3.
- Pulse width: PULSE_MASK=8'h01, PULSE_LEN=5, OUTSET=8'h01 -> bit0 high for exactly 5 cycles, busy high for 5 cycles, then bit0=0 and busy=0.
- Restart and length 0: PULSE_LEN=0 with a rise -> bit high for 1 cycle. With PULSE_LEN=4, write OUTCLEAR=1 then OUTSET=1 at count 2 -> counter reloads, bit0 high for 4 cycles after the second set.
- Expiry collision: issue OUTSET=8'h01 on the exact expiry cycle -> bit0 stays 1 and the counter reloads. Issue OUTSET=8'h02 with bit1 unmasked on the expiry cycle -> bit0 clears and bit1 sets.
- Reset and unmapped: reset_n low while busy with counter=3 -> out_port=RESET_VALUE, busy=0. Write address 6 with 32'hFFFFFFFF -> no register changes; read addresses 6, 7, 2, 3 -> 0.
